// File: rtl/ofdm_cp_remove.sv
// ofdm_cp_remove
// Receive-side OFDM cyclic-prefix remover placed between timing sync and the
// FFT input buffer. For each frame it discards CP_LEN prefix samples and
// forwards FFT_LEN body samples per symbol, for a run of symbols, framing
// each forwarded symbol with sop/eop and a symbol index.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   din_vld      input sample valid (no backpressure, gaps allowed)
//   din_i/din_q  input I/Q samples
//   frame_start  with din_vld: this sample is prefix sample 0 of symbol 0
//   sym_num      symbols per frame, captured on an accepted frame_start
//   dout_vld     output sample valid (one clock after the accepted input)
//   dout_i/q     output I/Q samples, bit-exact copy of the input
//   dout_sop     first body sample of a symbol
//   dout_eop     last body sample of a symbol
//   sym_idx      index of the symbol currently on dout
//   frame_done   pulse alongside eop of the frame's last symbol
//   sync_err     pulse when a frame_start arrives while a frame is in flight
module ofdm_cp_remove #(
  parameter int DW      = 16,
  parameter int FFT_LEN = 64,
  parameter int CP_LEN  = 16,
  parameter int SYM_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_vld,
  input  logic [DW-1:0]    din_i,
  input  logic [DW-1:0]    din_q,
  input  logic             frame_start,
  input  logic [SYM_W-1:0] sym_num,
  output logic             dout_vld,
  output logic [DW-1:0]    dout_i,
  output logic [DW-1:0]    dout_q,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic [SYM_W-1:0] sym_idx,
  output logic             frame_done,
  output logic             sync_err
);

  localparam int CPW = $clog2(CP_LEN);
  localparam int DTW = $clog2(FFT_LEN);
  localparam logic [CPW-1:0] CP_LAST  = CPW'(CP_LEN - 1);
  localparam logic [DTW-1:0] DAT_LAST = DTW'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CP,
    S_DATA
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CPW-1:0]   r_cp_cnt;
  logic [CPW-1:0]   w_cp_cnt_nxt;
  logic [DTW-1:0]   r_dat_cnt;
  logic [DTW-1:0]   w_dat_cnt_nxt;
  logic [SYM_W-1:0] r_sym_cnt;
  logic [SYM_W-1:0] w_sym_cnt_nxt;
  logic [SYM_W-1:0] r_sym_lim;
  logic [SYM_W-1:0] w_sym_lim_nxt;

  logic w_fwd;
  logic w_sop;
  logic w_eop;
  logic w_done;
  logic w_err;

  // State, counters and strobes for the sample presented this cycle.
  // An accepted frame_start always wins: the frame restarts with this sample
  // as prefix sample 0, so the prefix counter resumes at 1. Restarting while
  // a frame is in flight flags sync_err and swallows any eop due here.
  always_comb begin
    w_state_nxt   = r_state;
    w_cp_cnt_nxt  = r_cp_cnt;
    w_dat_cnt_nxt = r_dat_cnt;
    w_sym_cnt_nxt = r_sym_cnt;
    w_sym_lim_nxt = r_sym_lim;
    w_fwd         = 1'b0;
    w_sop         = 1'b0;
    w_eop         = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;

    if (din_vld) begin
      if (frame_start) begin
        w_err         = (r_state != S_IDLE);
        w_state_nxt   = S_CP;
        w_cp_cnt_nxt  = CPW'(1);
        w_sym_cnt_nxt = '0;
        // A zero symbol count would never terminate, so treat it as one.
        w_sym_lim_nxt = (sym_num == '0) ? SYM_W'(1) : sym_num;
      end else begin
        case (r_state)
          S_CP: begin
            if (r_cp_cnt == CP_LAST) begin
              w_state_nxt   = S_DATA;
              w_dat_cnt_nxt = '0;
            end else begin
              w_cp_cnt_nxt = r_cp_cnt + CPW'(1);
            end
          end
          S_DATA: begin
            w_fwd         = 1'b1;
            w_sop         = (r_dat_cnt == '0);
            w_eop         = (r_dat_cnt == DAT_LAST);
            w_dat_cnt_nxt = r_dat_cnt + DTW'(1);
            if (w_eop) begin
              if (r_sym_cnt == r_sym_lim - SYM_W'(1)) begin
                w_state_nxt = S_IDLE;
                w_done      = 1'b1;
              end else begin
                w_state_nxt   = S_CP;
                w_cp_cnt_nxt  = '0;
                w_sym_cnt_nxt = r_sym_cnt + SYM_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cp_cnt  <= '0;
      r_dat_cnt <= '0;
      r_sym_cnt <= '0;
      r_sym_lim <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cp_cnt  <= w_cp_cnt_nxt;
      r_dat_cnt <= w_dat_cnt_nxt;
      r_sym_cnt <= w_sym_cnt_nxt;
      r_sym_lim <= w_sym_lim_nxt;
    end
  end

  // Output register: strobes follow the forwarded sample, while data and
  // index only load on a forwarded sample so they hold between samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_vld   <= 1'b0;
      dout_i     <= '0;
      dout_q     <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      sym_idx    <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_vld   <= w_fwd;
      dout_sop   <= w_sop;
      dout_eop   <= w_eop;
      frame_done <= w_done;
      sync_err   <= w_err;
      if (w_fwd) begin
        dout_i  <= din_i;
        dout_q  <= din_q;
        sym_idx <= r_sym_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_cp_remove.sv
// tb_ofdm_cp_remove
// Self-checking bench for ofdm_cp_remove. Each driven sample is run through a
// position-based reference (frame position -> symbol / offset) and the
// predicted output is queued; the DUT output one clock later is popped and
// compared. Event counters give per-scenario totals from known frame layouts.
module tb_ofdm_cp_remove;

  localparam int DW      = 16;
  localparam int FFT_LEN = 64;
  localparam int CP_LEN  = 16;
  localparam int SYM_W   = 8;
  localparam int SYMLEN  = CP_LEN + FFT_LEN;

  logic             clk = 1'b0;
  logic             rst;
  logic             din_vld;
  logic [DW-1:0]    din_i;
  logic [DW-1:0]    din_q;
  logic             frame_start;
  logic [SYM_W-1:0] sym_num;
  logic             dout_vld;
  logic [DW-1:0]    dout_i;
  logic [DW-1:0]    dout_q;
  logic             dout_sop;
  logic             dout_eop;
  logic [SYM_W-1:0] sym_idx;
  logic             frame_done;
  logic             sync_err;

  ofdm_cp_remove #(
    .DW(DW), .FFT_LEN(FFT_LEN), .CP_LEN(CP_LEN), .SYM_W(SYM_W)
  ) dut (
    .clk(clk), .rst(rst),
    .din_vld(din_vld), .din_i(din_i), .din_q(din_q),
    .frame_start(frame_start), .sym_num(sym_num),
    .dout_vld(dout_vld), .dout_i(dout_i), .dout_q(dout_q),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .sym_idx(sym_idx),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             vld;
    logic [DW-1:0]    i;
    logic [DW-1:0]    q;
    logic             sop;
    logic             eop;
    logic [SYM_W-1:0] idx;
    logic             done;
    logic             err;
  } exp_t;

  typedef struct {
    logic             vld;
    logic             fs;
    logic [DW-1:0]    di;
    logic [DW-1:0]    dq;
    logic [SYM_W-1:0] symn;
    exp_t             exp;
  } vec_t;

  exp_t  expQ[$];
  vec_t  tab[8];
  int    checks = 0;
  int    passes = 0;
  string testName = "init";

  // Reference state: frame position counts accepted samples since frame_start.
  bit               mActive;
  int               mPos;
  int               mLim;
  logic [DW-1:0]    mLastI;
  logic [DW-1:0]    mLastQ;
  logic [SYM_W-1:0] mLastIdx;

  // Observed event totals per scenario.
  int nVld, nSop, nEop, nDone, nErr;
  int doneVal, sopAfterErrVal, sopAfterErrIdx;
  bit sawErr;

  function automatic exp_t zeroExp();
    exp_t z;
    z.vld = 1'b0; z.i = '0; z.q = '0; z.sop = 1'b0; z.eop = 1'b0;
    z.idx = '0; z.done = 1'b0; z.err = 1'b0;
    return z;
  endfunction

  task automatic modelReset();
    mActive = 1'b0; mPos = 0; mLim = 1;
    mLastI = '0; mLastQ = '0; mLastIdx = '0;
    expQ.delete();
  endtask

  task automatic modelStep(input logic vld, input logic fs, input logic [DW-1:0] di,
                           input logic [DW-1:0] dq, input logic [SYM_W-1:0] symn,
                           output exp_t e);
    int sym, off;
    e = zeroExp();
    e.i = mLastI; e.q = mLastQ; e.idx = mLastIdx;
    if (vld) begin
      if (fs) begin
        e.err   = mActive;
        mActive = 1'b1;
        mPos    = 1;
        mLim    = (symn == 0) ? 1 : int'(symn);
      end else if (mActive) begin
        sym = mPos / SYMLEN;
        off = mPos % SYMLEN;
        if (off >= CP_LEN) begin
          e.vld = 1'b1; e.i = di; e.q = dq; e.idx = SYM_W'(sym);
          e.sop = (off == CP_LEN);
          e.eop = (off == SYMLEN - 1);
          if (e.eop && sym == mLim - 1) begin
            e.done  = 1'b1;
            mActive = 1'b0;
          end
          mLastI = di; mLastQ = dq; mLastIdx = e.idx;
        end
        mPos++;
      end
    end
  endtask

  task automatic startTest(input string name);
    testName = name;
    nVld = 0; nSop = 0; nEop = 0; nDone = 0; nErr = 0;
    doneVal = -1; sopAfterErrVal = -1; sopAfterErrIdx = -1; sawErr = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      $display("[TB] FAIL %s scoreboard: DUT output sampled with no expected entry", testName);
    end else begin
      e = expQ.pop_front();
      if (dout_vld === e.vld && dout_i === e.i && dout_q === e.q && dout_sop === e.sop &&
          dout_eop === e.eop && sym_idx === e.idx && frame_done === e.done && sync_err === e.err)
        passes++;
      else
        $display("[TB] FAIL %s dout: got vld=%b i=%h q=%h sop=%b eop=%b idx=%0d done=%b err=%b, want vld=%b i=%h q=%h sop=%b eop=%b idx=%0d done=%b err=%b",
                 testName, dout_vld, dout_i, dout_q, dout_sop, dout_eop, sym_idx, frame_done, sync_err,
                 e.vld, e.i, e.q, e.sop, e.eop, e.idx, e.done, e.err);
    end
    if (dout_vld) nVld++;
    if (dout_sop) nSop++;
    if (dout_eop) nEop++;
    if (frame_done) begin nDone++; doneVal = int'(dout_i); end
    if (sync_err) begin nErr++; sawErr = 1'b1; end
    if (dout_sop && sawErr && sopAfterErrVal < 0) begin
      sopAfterErrVal = int'(dout_i);
      sopAfterErrIdx = int'(sym_idx);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("[TB] FAIL %s %s: got %0d, want %0d", testName, name, got, want);
  endtask

  task automatic checkIdleOutputs(input string name);
    checks++;
    if (dout_vld === 1'b0 && dout_i === '0 && dout_q === '0 && dout_sop === 1'b0 &&
        dout_eop === 1'b0 && sym_idx === '0 && frame_done === 1'b0 && sync_err === 1'b0)
      passes++;
    else
      $display("[TB] FAIL %s: got vld=%b i=%h q=%h sop=%b eop=%b idx=%0d done=%b err=%b, want all zero",
               name, dout_vld, dout_i, dout_q, dout_sop, dout_eop, sym_idx, frame_done, sync_err);
  endtask

  task automatic applyStimulus(input logic vld, input logic fs, input logic [DW-1:0] di,
                               input logic [DW-1:0] dq, input logic [SYM_W-1:0] symn);
    exp_t e;
    @(negedge clk);
    din_vld = vld; frame_start = fs; din_i = di; din_q = dq; sym_num = symn;
    modelStep(vld, fs, di, dq, symn, e);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyVector(input vec_t v);
    exp_t e;
    @(negedge clk);
    din_vld = v.vld; frame_start = v.fs; din_i = v.di; din_q = v.dq; sym_num = v.symn;
    modelStep(v.vld, v.fs, v.di, v.dq, v.symn, e);
    expQ.push_back(v.exp);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  function automatic logic [DW-1:0] qOf(input int k);
    return DW'(k) ^ 16'hA000;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Stray frame_start with din_vld low, then valid samples without frame_start.
    for (int k = 0; k < 8; k++) begin
      tab[k].vld  = (k >= 1 && k <= 6);
      tab[k].fs   = (k == 0);
      tab[k].di   = DW'(100 + k);
      tab[k].dq   = DW'(200 + k);
      tab[k].symn = 8'd2;
      tab[k].exp  = zeroExp();
    end

    rst = 1'b1; din_vld = 1'b0; frame_start = 1'b0;
    din_i = '0; din_q = '0; sym_num = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset state");
    @(negedge clk);
    rst = 1'b0;

    startTest("T6 idle");
    foreach (tab[k]) applyVector(tab[k]);
    checkCount("vld count", nVld, 0);
    checkCount("sync_err count", nErr, 0);

    startTest("T1 contiguous");
    for (int k = 0; k < 160; k++) applyStimulus(1'b1, k == 0, DW'(k), qOf(k), 8'd2);
    applyStimulus(1'b0, 1'b0, '0, '0, 8'd2);
    checkCount("vld count", nVld, 128);
    checkCount("sop count", nSop, 2);
    checkCount("eop count", nEop, 2);
    checkCount("done count", nDone, 1);
    checkCount("done sample", doneVal, 159);

    startTest("T2 gapped");
    for (int k = 0; k < 160; k++) begin
      applyStimulus(1'b1, k == 0, DW'(k), qOf(k), 8'd2);
      applyStimulus(1'b0, (k % 7) == 3, 16'hFFFF, 16'hFFFF, 8'd2);
    end
    checkCount("vld count", nVld, 128);
    checkCount("sop count", nSop, 2);
    checkCount("done sample", doneVal, 159);
    checkCount("sync_err count", nErr, 0);

    startTest("T3 resync in data");
    for (int k = 0; k < 200; k++) applyStimulus(1'b1, k == 0 || k == 40, DW'(k), qOf(k), 8'd2);
    checkCount("sync_err count", nErr, 1);
    checkCount("sop count", nSop, 3);
    checkCount("eop count", nEop, 2);
    checkCount("done sample", doneVal, 199);
    checkCount("sop after resync", sopAfterErrVal, 56);
    checkCount("sym_idx after resync", sopAfterErrIdx, 0);

    startTest("T4 sym_num zero");
    for (int k = 0; k < 100; k++) applyStimulus(1'b1, k == 0, DW'(k), qOf(k), 8'd0);
    checkCount("vld count", nVld, 64);
    checkCount("done count", nDone, 1);
    checkCount("done sample", doneVal, 79);

    startTest("T5 async reset");
    for (int k = 0; k < 50; k++) applyStimulus(1'b1, k == 0, DW'(k), qOf(k), 8'd2);
    #2;
    rst = 1'b1;
    #1;
    checkIdleOutputs("T5 outputs during reset");
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    startTest("T5 after reset");
    for (int k = 50; k < 80; k++) applyStimulus(1'b1, 1'b0, DW'(k), qOf(k), 8'd2);
    checkCount("vld before frame_start", nVld, 0);
    for (int k = 0; k < 80; k++) applyStimulus(1'b1, k == 0, DW'(k), qOf(k), 8'd1);
    checkCount("vld count", nVld, 64);
    checkCount("done count", nDone, 1);

    startTest("T7 resync on eop");
    for (int k = 0; k < 160; k++) applyStimulus(1'b1, k == 0 || k == 79, DW'(k), qOf(k), 8'd1);
    checkCount("sync_err count", nErr, 1);
    checkCount("eop count", nEop, 1);
    checkCount("done count", nDone, 1);
    checkCount("done sample", doneVal, 158);
    checkCount("vld count", nVld, 127);

    startTest("T8 resync in prefix");
    for (int k = 0; k < 90; k++) applyStimulus(1'b1, k == 0 || k == 5, DW'(k), qOf(k), 8'd1);
    checkCount("sync_err count", nErr, 1);
    checkCount("sop after resync", sopAfterErrVal, 21);
    checkCount("done sample", doneVal, 84);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
